seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds an 8-entry × 4-bit digit register file and steps through the digits at a programmable refresh rate. Each step it presents a coherent `num`/`sel` pair, and those outputs drive the `num`/`sel` inputs of the downstream hex-to-segment decoder/anode driver. Host logic writes digits individually or loads all eight at once.

---
 rtl/seg_scan_ctrl.sv | 70 +++++++
 tb/tb_seg_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display.
// Holds the digit values and steps a registered num/sel pair through the digits at a fixed rate.
module seg_scan_ctrl #(
  parameter int DIV = 100000,
  parameter int CW  = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        load_en,
  input  logic [31:0] load_data,
  input  logic        hold,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        frame
);

  localparam logic [CW-1:0] PC_LAST = CW'(DIV - 1);

  logic [3:0]    digit      [8];
  logic [3:0]    digit_next [8];
  logic [CW-1:0] pc;
  logic [CW-1:0] pc_next;
  logic [2:0]    sel_next;
  logic          frame_next;
  logic          step;

  // A single write overrides the bulk load for the same index.
  always_comb begin
    digit_next = digit;
    if (load_en) begin
      for (int k = 0; k < 8; k++) begin
        digit_next[k] = load_data[4*k +: 4];
      end
    end
    if (wr_en) begin
      digit_next[wr_addr] = wr_data;
    end

    step       = !hold && (pc == PC_LAST);
    pc_next    = pc;
    if (!hold) begin
      pc_next = step ? '0 : pc + 1'b1;
    end
    sel_next   = step ? sel + 3'd1 : sel;
    frame_next = step && (sel == 3'd7);
  end

  // num is taken from next-state digits and sel so the pair always changes together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        digit[k] <= 4'd0;
      end
      pc    <= '0;
      sel   <= 3'd0;
      num   <= 4'd0;
      frame <= 1'b0;
    end else begin
      digit <= digit_next;
      pc    <= pc_next;
      sel   <= sel_next;
      num   <= digit_next[sel_next];
      frame <= frame_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=4.
// A cycle model pushes expected outputs to a scoreboard; directed checks cover the test plan points.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int CW  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        load_en;
  logic [31:0] load_data;
  logic        hold;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        frame;

  seg_scan_ctrl #(.DIV(DIV), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .load_en   (load_en),
    .load_data (load_data),
    .hold      (hold),
    .num       (num),
    .sel       (sel),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] num;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  int pass_count  = 0;
  int check_count = 0;

  logic [3:0] m_digit [8];
  int         m_pc    = 0;
  int         m_sel   = 0;
  logic       m_frame = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check_count++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check_val("sb_sel", 32'(sel), 32'(e.sel));
      check_val("sb_num", 32'(num), 32'(e.num));
      check_val("sb_frame", 32'(frame), 32'(e.frame));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                               input logic [3:0] wd, input logic le,
                               input logic [31:0] ld, input logic hd);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    load_en   = le;
    load_data = ld;
    hold      = hd;

    if (rst) begin
      for (int k = 0; k < 8; k++) m_digit[k] = 4'd0;
      m_pc    = 0;
      m_sel   = 0;
      m_frame = 1'b0;
    end else begin
      if (le) for (int k = 0; k < 8; k++) m_digit[k] = ld[4*k +: 4];
      if (we) m_digit[wa] = wd;
      m_frame = 1'b0;
      if (!hd) begin
        if (m_pc == DIV - 1) begin
          m_pc    = 0;
          m_frame = (m_sel == 7);
          m_sel   = (m_sel + 1) % 8;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
    e.sel   = 3'(m_sel);
    e.num   = m_digit[m_sel];
    e.frame = m_frame;
    sb.push_back(e);

    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd0, 4'd0, 0, 32'd0, 0);
  endtask

  task automatic run_until(input int s, input int p);
    for (int i = 0; i < 100; i++) begin
      if (m_sel == s && m_pc == p) return;
      idle(1);
    end
    check_count++;
    $error("[TB] FAIL run_until_timeout: observed no match expected sel %0d pc %0d", s, p);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    load_en = 1'b0; load_data = 32'd0; hold = 1'b0;

    // Reset and idle scan
    applyStimulus(1, 0, 3'd0, 4'd0, 0, 32'd0, 0);
    applyStimulus(1, 0, 3'd0, 4'd0, 0, 32'd0, 0);
    check_val("reset_sel", 32'(sel), 32'd0);
    check_val("reset_num", 32'(num), 32'd0);
    check_val("reset_frame", 32'(frame), 32'd0);
    idle(3);
    check_val("first_dwell_sel", 32'(sel), 32'd0);
    idle(1);
    check_val("first_step_sel", 32'(sel), 32'd1);
    idle(40);

    // Bulk load
    applyStimulus(0, 0, 3'd0, 4'd0, 1, 32'h76543210, 0);
    run_until(7, 0);
    check_val("load_sel7_num", 32'(num), 32'h7);
    idle(32);

    // Single write to the displayed digit
    run_until(3, 1);
    applyStimulus(0, 1, 3'd3, 4'hA, 0, 32'd0, 0);
    check_val("write_disp_num", 32'(num), 32'hA);
    check_val("write_disp_sel", 32'(sel), 32'd3);

    // Simultaneous load and write
    applyStimulus(0, 1, 3'd5, 4'h2, 1, 32'hFFFFFFFF, 0);
    run_until(5, 0);
    check_val("loadwr_sel5_num", 32'(num), 32'h2);
    run_until(6, 0);
    check_val("loadwr_sel6_num", 32'(num), 32'hF);
    idle(32);

    // Hold at sel=2, pc=1 with a write to the held digit
    run_until(2, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        applyStimulus(0, 1, 3'd2, 4'hC, 0, 32'd0, 1);
        check_val("hold_write_num", 32'(num), 32'hC);
      end else begin
        applyStimulus(0, 0, 3'd0, 4'd0, 0, 32'd0, 1);
      end
      check_val("hold_frame", 32'(frame), 32'd0);
    end
    check_val("hold_sel", 32'(sel), 32'd2);
    idle(2);
    check_val("hold_resume_sel", 32'(sel), 32'd2);
    idle(1);
    check_val("hold_step_sel", 32'(sel), 32'd3);
    idle(20);

    // Mid-scan reset after bulk load
    applyStimulus(0, 0, 3'd0, 4'd0, 1, 32'h89ABCDEF, 0);
    run_until(6, 1);
    check_val("pre_reset_num", 32'(num), 32'h9);
    applyStimulus(1, 0, 3'd0, 4'd0, 0, 32'd0, 0);
    check_val("midreset_sel", 32'(sel), 32'd0);
    check_val("midreset_num", 32'(num), 32'd0);
    check_val("midreset_frame", 32'(frame), 32'd0);
    for (int i = 0; i < 8 * DIV; i++) begin
      idle(1);
      check_val("post_reset_num", 32'(num), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
